// File: rtl/panda_pkg.sv
// Shared register-file constants and types for the Panda pipeline.
package panda_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/panda_scoreboard.sv
// Register scoreboard: tracks registers owned by long-latency ops (loads, mul/div)
// and holds the instruction in ID on RAW/WAW hazards against them or on full capacity.
module panda_scoreboard
    import panda_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 issue_valid_i,
    input  logic [4:0]                           issue_rd_addr_i,
    input  logic                                 issue_rd_we_i,
    input  logic                                 issue_long_i,
    input  logic [4:0]                           rs1_addr_i,
    input  logic [4:0]                           rs2_addr_i,
    input  logic                                 rs1_used_i,
    input  logic                                 rs2_used_i,
    input  logic                                 wb_valid_i,
    input  logic [4:0]                           wb_rd_addr_i,
    output logic                                 stall_o,
    output logic [31:0]                          pending_o,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
    output logic                                 full_o
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    // Interface semantics: issue_valid_i is a one-cycle strobe, high only when the
    // ID instruction actually moves to EX (upstream already gated it with ~stall_o);
    // wb_valid_i is a one-cycle strobe per long-latency RF write. No backpressure.

    logic [NUM_REGS-1:0] r_pending;
    logic [NUM_REGS-1:0] w_pending_nxt;
    logic [CNT_W-1:0]    r_count;
    logic [CNT_W-1:0]    w_count_nxt;
    reg_addr_t           w_issue_rd;
    reg_addr_t           w_wb_rd;
    logic                w_full;
    logic                w_mark_req;
    logic                w_mark;
    logic                w_clear;
    logic                w_raw1;
    logic                w_raw2;
    logic                w_waw;
    logic                w_cap;

    assign w_issue_rd = issue_rd_addr_i;
    assign w_wb_rd    = wb_rd_addr_i;

    always_comb begin
        w_full     = (r_count == CNT_W'(MAX_OUTSTANDING));
        w_mark_req = issue_valid_i & issue_rd_we_i & issue_long_i & (w_issue_rd != '0);
        w_mark     = w_mark_req & ~w_full;
        w_clear    = wb_valid_i & (w_wb_rd != '0) & r_pending[w_wb_rd];
    end

    // Clear is applied before mark so a same-register collision leaves the bit set.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_clear) begin
            w_pending_nxt[w_wb_rd] = 1'b0;
        end
        if (w_mark) begin
            w_pending_nxt[w_issue_rd] = 1'b1;
        end
        w_pending_nxt[0] = 1'b0;

        w_count_nxt = r_count;
        case ({w_mark, w_clear})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pending <= '0;
            r_count   <= '0;
        end else begin
            r_pending <= w_pending_nxt;
            r_count   <= w_count_nxt;
        end
    end

    // Hazards are judged from registered state only; a writeback this cycle does not release.
    always_comb begin
        w_raw1  = rs1_used_i & (rs1_addr_i != '0) & r_pending[rs1_addr_i];
        w_raw2  = rs2_used_i & (rs2_addr_i != '0) & r_pending[rs2_addr_i];
        w_waw   = issue_rd_we_i & (w_issue_rd != '0) & r_pending[w_issue_rd];
        w_cap   = issue_long_i & issue_rd_we_i & (w_issue_rd != '0) & w_full;
        stall_o = w_raw1 | w_raw2 | w_waw | w_cap;
    end

    assign pending_o     = r_pending;
    assign outstanding_o = r_count;
    assign full_o        = w_full;

    a_clear_is_pending : assert property (@(posedge clk_i) disable iff (!rst_ni)
        wb_valid_i |-> ((wb_rd_addr_i != '0) && r_pending[wb_rd_addr_i]));

    a_mark_not_full : assert property (@(posedge clk_i) disable iff (!rst_ni)
        w_mark_req |-> !w_full);

endmodule
